frequency_meter: RTL and testbench
==================================

# frequency_meter

Measures the frequency of an external square wave by counting its rising edges over a fixed gate window of CPU clock cycles. It reports the result as a 15-bit value on the same scale as the `frequency` input of the DDS phase accumulator, so software can read back and close the loop against the tone generator. It sits on the CPU clock domain behind a memory-mapped register wrapper. `signal_in` is asynchronous and synchronized internally.

## Interface
- `CPU_CLOCK_FREQ`, 50_000_000: CPU clock rate in Hz.
- `GATE_CYCLES`, `CPU_CLOCK_FREQ`: gate window length in clock cycles. The default gives a result in Hz. Must be ≥ 4.
- `clk` input 1: CPU clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: measurement runs while high.
- `signal_in` input 1: asynchronous square wave under measurement.
- `freq` output 15: last completed edge count, saturated at 32767.
- `freq_valid` output 1: `freq` holds an unconsumed result.
- `freq_ready` input 1: consumer accepts `freq` when high with `freq_valid`.
- `overrun` output 1: sticky; a result was overwritten before it was consumed.
- `overrun_clr` input 1: synchronous clear of `overrun`.

## Operation
- Input path:
  - Two-flop synchronizer, then a registered previous sample.
  - `edge_pulse` = sync & ~prev, one cycle per rising edge.
  - The synchronizer and previous-sample flops reset to 0, so a high `signal_in` at reset release produces one edge.
- State machine, two states:
  - IDLE: `enable`=1 → MEASURE. On entry, `gate_cnt` = `GATE_CYCLES`-1 and `edge_cnt` = 0.
  - MEASURE, each cycle:
    - `edge_pulse` increments `edge_cnt`, saturating at 32767.
    - `gate_cnt` decrements.
    - `enable`=0 → IDLE, window discarded, no result produced.
    - At `gate_cnt`==0 the window ends:
      - `freq` ← `edge_cnt` plus this cycle's edge (saturated).
      - `freq_valid` ← 1.
      - If `enable`=1, `gate_cnt` reloads and `edge_cnt` clears (0, or 1 if a new edge arrives next cycle). No dead cycle between windows.
      - If `enable`=0, go to IDLE.
- Handshake:
  - `freq_valid` falls the cycle after `freq_valid`&`freq_ready`.
  - `freq` is stable while `freq_valid`=1 unless overwritten by a new result.
  - New result in the same cycle as an accept: `freq_valid` stays 1 with the new value; no overrun.
  - New result while `freq_valid`=1 and `freq_ready`=0: value overwritten; `overrun` handling per Configuration.
- `overrun_clr` and an overrun event in the same cycle: set wins.
- Widths:
  - `gate_cnt` is `$clog2(GATE_CYCLES)` bits.
  - `edge_cnt` is 15 bits with explicit saturation. No wrap.

## Timing
- Reset values: `freq`=0, `freq_valid`=0, `overrun`=0, state IDLE, all counters 0.
- `signal_in` to `edge_pulse` latency: 3 cycles.
- A window is exactly `GATE_CYCLES` cycles, counted from the cycle after `enable` is sampled high in IDLE.
- `freq_valid` rises the cycle after the last window cycle.
- Maximum measurable edge rate is one edge per 2 clk cycles. Faster inputs alias and are not in scope.
- Reset assertion mid-window:
  - All state clears immediately (asynchronous).
  - The partial count is lost.
  - After release, measurement restarts from IDLE.

## Configuration
- `FREQ_METER_OVERRUN_EN`:
  - Defined: `overrun` flag and `overrun_clr` logic are built as above.
  - Undefined: `overrun` is tied to 0, `overrun_clr` is ignored, and overwrites are silent.

## Structure
- `freq_meter_pkg` holds:
  - The state enum (IDLE, MEASURE).
  - `FREQ_W`=15.
  - `FREQ_MAX`=15'h7FFF.
- Sub-module `sync_edge_detect` (two-flop synchronizer plus rising-edge pulse). It is reusable for other asynchronous inputs such as buttons.

## Test plan
Use `GATE_CYCLES`=100 unless noted.
1. Reset mid-window, then release with `enable`=1 and `signal_in` toggling every 5 cycles (period 10) → `freq`=10 after each window; `freq_valid` rises 101 cycles after enable.
2. `signal_in` toggling every cycle with `GATE_CYCLES`=70000 → `freq`=32767 (saturated), no wrap.
3. `enable` dropped at cycle 50 of a window → no `freq_valid`; re-enable gives a full fresh 100-cycle window.
4. `freq_ready`=0 across two windows → second result overwrites; `overrun`=1 with the macro, 0 without. `overrun_clr` pulse clears it; clear and event in the same cycle leaves it 1.
5. `freq_ready`=1 on the exact cycle a new result lands → `freq_valid` stays 1 with the new value; `overrun` stays 0.
6. Edge arriving on the last window cycle is counted in that window; edge on the first cycle of the next window is counted in the next window. Totals across consecutive windows equal the total edges driven.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM states, result width, saturation helper.
// Pure declarations; no latency, no backpressure.
package freq_meter_pkg;

    localparam int              FREQ_W   = 15;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 15'h7FFF;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] cnt, input logic inc);
        sat_inc = (inc && (cnt != FREQ_MAX)) ? cnt + FREQ_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus registered previous sample; one-cycle pulse per rising edge of din.
// din to edge_pulse is 3 clk edges (pulse counted on the third); no backpressure.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_pulse
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        prev_d = sync_q[1];
    end

    // Zero reset means a level already high at release reads as one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/frequency_meter.sv
// Counts signal_in rising edges over GATE_CYCLES clocks; result valid 1 cycle after the window, held until accepted.
// Overwrites are flagged by the sticky overrun only when FREQ_METER_OVERRUN_EN is defined.
module frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int GATE_CYCLES    = CPU_CLOCK_FREQ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              signal_in,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    input  logic              freq_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    // A gate shorter than the pipeline is meaningless; fall back to a one-second window.
    localparam int             GATE_LEN  = (GATE_CYCLES >= 4) ? GATE_CYCLES : CPU_CLOCK_FREQ;
    localparam int             GW        = $clog2(GATE_LEN);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_LEN - 1);

    logic              edge_pulse;
    state_t            state_q, state_d;
    logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
    logic [FREQ_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              freq_valid_q, freq_valid_d;
    logic [FREQ_W-1:0] edge_sum;
    logic              new_result;

    sync_edge_detect u_sync (
        .clk        (clk),
        .rst        (rst),
        .din        (signal_in),
        .edge_pulse (edge_pulse)
    );

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        freq_d     = freq_q;
        new_result = 1'b0;
        edge_sum   = sat_inc(edge_cnt_q, edge_pulse);
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = MEASURE;
                    gate_cnt_d = GATE_LAST;
                    edge_cnt_d = '0;
                end
            end
            MEASURE: begin
                // The last window cycle still contributes its own edge.
                if (gate_cnt_q == '0) begin
                    new_result = 1'b1;
                    freq_d     = edge_sum;
                    if (enable) begin
                        gate_cnt_d = GATE_LAST;
                        edge_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q - GW'(1);
                    edge_cnt_d = edge_sum;
                end
            end
            default: state_d = IDLE;
        endcase
        freq_valid_d = new_result | (freq_valid_q & ~freq_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;

`ifdef FREQ_METER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // A new overwrite in the same cycle as a clear keeps the flag set.
    always_comb begin
        overrun_d = (new_result & freq_valid_q & ~freq_ready) | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = overrun_clr;
    assign overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: 100-cycle gate instance for function, 70000-cycle instance for saturation.
module tb_frequency_meter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        freq_ready;
    logic        overrun_clr;
    logic [14:0] freq;
    logic        freq_valid;
    logic        overrun;
    logic        signal_in;

    logic        gen_on;
    logic        gen_sig;
    int          gen_cnt;
    logic        man_sig;

    logic        rst_s;
    logic        enable_s;
    logic        fast_sig;
    logic [14:0] freq_s;
    logic        valid_s;
    logic        overrun_s;

    int tests_run;
    int tests_failed;

`ifdef FREQ_METER_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    assign signal_in = gen_on ? gen_sig : man_sig;

    frequency_meter #(.CPU_CLOCK_FREQ(50_000_000), .GATE_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .signal_in   (signal_in),
        .freq        (freq),
        .freq_valid  (freq_valid),
        .freq_ready  (freq_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    frequency_meter #(.CPU_CLOCK_FREQ(50_000_000), .GATE_CYCLES(70000)) dut_sat (
        .clk         (clk),
        .rst         (rst_s),
        .enable      (enable_s),
        .signal_in   (fast_sig),
        .freq        (freq_s),
        .freq_valid  (valid_s),
        .freq_ready  (1'b0),
        .overrun     (overrun_s),
        .overrun_clr (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square wave with period 10 cycles, restarting low whenever it is switched on.
    always @(negedge clk) begin
        if (!gen_on) begin
            gen_sig = 1'b0;
            gen_cnt = 0;
        end else if (gen_cnt == 4) begin
            gen_sig = ~gen_sig;
            gen_cnt = 0;
        end else begin
            gen_cnt = gen_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (enable_s) fast_sig = ~fast_sig;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        tick(3);
        tests_run++;
        if (freq !== 15'd0) begin tests_failed++; $display("FAIL reset_freq got %0d want 0", freq); end
        tests_run++;
        if (freq_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", freq_valid); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_window_after_reset;
        int rise;
        rst = 1'b1; enable = 1'b1; freq_ready = 1'b1; gen_on = 1'b1;
        tick(40);
        rst = 1'b0;
        tick(3);
        tests_run++;
        if (freq_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_valid got %b want 0", freq_valid); end
        tests_run++;
        if (freq !== 15'd0) begin tests_failed++; $display("FAIL midreset_freq got %0d want 0", freq); end
        gen_on = 1'b0;
        tick(2);
        rst = 1'b1; gen_on = 1'b1;
        rise = 0;
        for (int i = 1; i <= 200 && rise == 0; i++) begin
            @(negedge clk);
            if (freq_valid === 1'b1) rise = i;
        end
        tests_run++;
        if (rise != 101) begin tests_failed++; $display("FAIL first_valid_cycle got %0d want 101", rise); end
        tests_run++;
        if (freq !== 15'd10) begin tests_failed++; $display("FAIL window1_freq got %0d want 10", freq); end
        tick(1);
        tests_run++;
        if (freq_valid !== 1'b0) begin tests_failed++; $display("FAIL accept_drop got %b want 0", freq_valid); end
        tick(99);
        tests_run++;
        if (freq_valid !== 1'b1 || freq !== 15'd10) begin
            tests_failed++; $display("FAIL window2 got valid=%b freq=%0d want valid=1 freq=10", freq_valid, freq);
        end
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_abort;
        int rise;
        logic seen;
        @(negedge clk);
        enable = 1'b1;
        tick(50);
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (freq_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_no_result got %b want 0", seen); end
        enable = 1'b1;
        rise = 0;
        for (int i = 1; i <= 200 && rise == 0; i++) begin
            @(negedge clk);
            if (freq_valid === 1'b1) rise = i;
        end
        tests_run++;
        if (rise != 101) begin tests_failed++; $display("FAIL reenable_valid_cycle got %0d want 101", rise); end
        tests_run++;
        if (freq !== 15'd10) begin tests_failed++; $display("FAIL reenable_freq got %0d want 10", freq); end
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_overrun;
        @(negedge clk);
        freq_ready = 1'b0; overrun_clr = 1'b0; enable = 1'b1;
        tick(101);
        tests_run++;
        if (freq_valid !== 1'b1 || freq !== 15'd10) begin
            tests_failed++; $display("FAIL ovr_first got valid=%b freq=%0d want valid=1 freq=10", freq_valid, freq);
        end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_first_flag got %b want 0", overrun); end
        tick(100);
        tests_run++;
        if (freq_valid !== 1'b1 || freq !== 15'd10) begin
            tests_failed++; $display("FAIL ovr_second got valid=%b freq=%0d want valid=1 freq=10", freq_valid, freq);
        end
        tests_run++;
        if (overrun !== EXP_OVR) begin tests_failed++; $display("FAIL ovr_set got %b want %b", overrun, EXP_OVR); end
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
        tick(98);
        overrun_clr = 1'b1;
        tick(1);
        tests_run++;
        if (overrun !== EXP_OVR) begin tests_failed++; $display("FAIL ovr_set_wins got %b want %b", overrun, EXP_OVR); end
        tick(1);
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear2 got %b want 0", overrun); end
    endtask

    task automatic test_accept_collision;
        tick(98);
        freq_ready = 1'b1;
        tick(1);
        tests_run++;
        if (freq_valid !== 1'b1 || freq !== 15'd10) begin
            tests_failed++; $display("FAIL collide got valid=%b freq=%0d want valid=1 freq=10", freq_valid, freq);
        end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL collide_overrun got %b want 0", overrun); end
        enable = 1'b0;
        tick(1);
        tests_run++;
        if (freq_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_drop got %b want 0", freq_valid); end
        tick(3);
    endtask

    task automatic test_edge_boundary;
        int rises [5] = '{10, 98, 150, 199, 250};
        int exp_w [3] = '{2, 1, 2};
        int total;
        logic hi;
        gen_on = 1'b0; man_sig = 1'b0; freq_ready = 1'b1;
        tick(10);
        enable = 1'b1;
        total = 0;
        for (int t = 1; t <= 301; t++) begin
            @(negedge clk);
            if (t % 100 == 1 && t > 1) begin
                tests_run++;
                if (freq_valid !== 1'b1 || freq !== 15'(exp_w[t / 100 - 1])) begin
                    tests_failed++;
                    $display("FAIL boundary_w%0d got valid=%b freq=%0d want valid=1 freq=%0d",
                             t / 100, freq_valid, freq, exp_w[t / 100 - 1]);
                end
                if (freq_valid === 1'b1) total = total + int'(freq);
            end
            hi = 1'b0;
            for (int r = 0; r < 5; r++) if (t == rises[r] || t == rises[r] + 1) hi = 1'b1;
            man_sig = hi;
        end
        tests_run++;
        if (total != 5) begin tests_failed++; $display("FAIL boundary_total got %0d want 5", total); end
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 75000 && valid_s !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (valid_s !== 1'b1) begin tests_failed++; $display("FAIL sat_valid got %b want 1 (timeout)", valid_s); end
        tests_run++;
        if (freq_s !== 15'h7FFF) begin tests_failed++; $display("FAIL sat_freq got %0d want 32767", freq_s); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b0; rst_s = 1'b0; enable = 1'b0; freq_ready = 1'b0; overrun_clr = 1'b0;
        gen_on = 1'b0; man_sig = 1'b0; enable_s = 1'b0; fast_sig = 1'b0;
        test_reset;
        rst_s = 1'b1; enable_s = 1'b1;
        test_window_after_reset;
        test_abort;
        test_overrun;
        test_accept_collision;
        test_edge_boundary;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
